// File: rtl/onchip_mem_avl_slave.sv
// onchip_mem_avl_slave: parametrised Avalon-MM on-chip RAM slave with
// configurable width/depth, 1- or 2-cycle read latency, clock-enable stalls,
// a hardware zero-fill engine and out-of-range address handling.
// Optional build macro ONCHIP_MEM_OOR_ERR_EN adds a sticky out-of-range
// error flag with first-offender address capture (oor_clr/oor_err/oor_addr).
module onchip_mem_avl_slave #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 15,
  parameter int DEPTH          = 25000,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W/8-1:0]   byteenable,
  input  logic                  chipselect,
  input  logic                  read,
  input  logic                  write,
  input  logic [DATA_W-1:0]     writedata,
  input  logic                  clken,
  input  logic                  reset_req,
  input  logic                  clear_req,
  output logic [DATA_W-1:0]     readdata,
  output logic                  readdatavalid,
  output logic                  waitrequest,
  output logic                  clear_busy,
  output logic                  clear_done
`ifdef ONCHIP_MEM_OOR_ERR_EN
  ,
  input  logic                  oor_clr,
  output logic                  oor_err,
  output logic [ADDR_W-1:0]     oor_addr
`endif
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // DEPTH may equal 2^ADDR_W, so the range compare needs one extra bit.
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              done_d;
  logic              clr_wr;

  logic              en;
  logic              accept;
  logic              wr_acc;
  logic              rd_acc;
  logic              in_range;
  logic [IDX_W-1:0]  mem_idx;
  logic [IDX_W-1:0]  clr_idx;

  logic              rd_v1;
  logic [DATA_W-1:0] rd_d1;

  assign en          = clken & ~reset_req;
  assign clear_busy  = (state_q == CLEAR);
  assign waitrequest = ~en | clear_busy;
  assign accept      = chipselect & (read | write) & ~waitrequest;
  assign wr_acc      = accept & write;
  assign rd_acc      = accept & read & ~write;
  assign in_range    = ({1'b0, address} < DEPTH_X);
  assign mem_idx     = address[IDX_W-1:0];
  assign clr_idx     = clr_cnt_q[IDX_W-1:0];

  // Clear FSM state, sweep counter and the registered completion pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      clr_cnt_q  <= '0;
      clear_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      clear_done <= done_d;
    end
  end

  // Clear FSM next state: one zero word per enabled cycle, stop after the last word.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    done_d    = 1'b0;
    clr_wr    = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_req && en) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end
      end
      CLEAR: begin
        if (en) begin
          clr_wr = 1'b1;
          if (clr_cnt_q == LAST_WORD) begin
            state_d   = IDLE;
            clr_cnt_d = '0;
            done_d    = 1'b1;
          end else begin
            clr_cnt_d = clr_cnt_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // RAM array write port: the clear sweep and bus writes never overlap, since
  // waitrequest blocks commands while clearing.
  always_ff @(posedge clk) begin
    if (clr_wr) begin
      mem[clr_idx] <= '0;
    end else if (wr_acc && in_range) begin
      for (int i = 0; i < BE_W; i++) begin
        if (byteenable[i]) begin
          mem[mem_idx][i*8 +: 8] <= writedata[i*8 +: 8];
        end
      end
    end
  end

  // First read stage: synchronous RAM read, zero for out-of-range, frozen while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_v1 <= 1'b0;
      rd_d1 <= '0;
    end else if (en) begin
      rd_v1 <= rd_acc;
      if (rd_acc) begin
        rd_d1 <= in_range ? mem[mem_idx] : '0;
      end
    end
  end

  generate
    if (READ_LATENCY >= 2) begin : g_lat2
      logic              rd_v2;
      logic [DATA_W-1:0] rd_d2;

      // Extra output register stage, advancing only on enabled cycles.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          rd_v2 <= 1'b0;
          rd_d2 <= '0;
        end else if (en) begin
          rd_v2 <= rd_v1;
          rd_d2 <= rd_d1;
        end
      end

      assign readdatavalid = rd_v2 & en;
      assign readdata      = rd_d2;
    end else begin : g_lat1
      assign readdatavalid = rd_v1 & en;
      assign readdata      = rd_d1;
    end
  endgenerate

`ifdef ONCHIP_MEM_OOR_ERR_EN
  logic oor_hit;

  assign oor_hit = accept & ~in_range;

  // Sticky out-of-range flag keeping the first offending address; a new
  // violation beats a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      oor_err  <= 1'b0;
      oor_addr <= '0;
    end else if (oor_hit && (!oor_err || oor_clr)) begin
      oor_err  <= 1'b1;
      oor_addr <= address;
    end else if (oor_clr) begin
      oor_err  <= 1'b0;
      oor_addr <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_onchip_mem_avl_slave.sv
// tb_onchip_mem_avl_slave: scoreboard bench driving two instances in lockstep,
// one with READ_LATENCY=1/no reset clear and one with READ_LATENCY=2/clear on
// reset. Optional ONCHIP_MEM_OOR_ERR_EN also checks the out-of-range flag.
module tb_onchip_mem_avl_slave;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int BW    = DW / 8;
  localparam int DEPTH = 20;
  localparam logic [1:0] COR = 2'b10;

  typedef struct packed {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic          clk;
  logic          reset_n;
  logic [AW-1:0] address;
  logic [BW-1:0] byteenable;
  logic          chipselect;
  logic          read;
  logic          write;
  logic [DW-1:0] writedata;
  logic          clken;
  logic          reset_req;
  logic          clear_req;
  logic [DW-1:0] rdata [2];
  logic [1:0]    rdv;
  logic [1:0]    wreq;
  logic [1:0]    busy;
  logic [1:0]    done;
`ifdef ONCHIP_MEM_OOR_ERR_EN
  logic          oor_clr;
  logic [1:0]    oor_err;
  logic [AW-1:0] oor_addr [2];
  bit            moor_err [2];
  logic [AW-1:0] moor_addr [2];
`endif

  logic [DW-1:0] mmem [2][DEPTH];
  bit            mbusy [2];
  int            mleft [2];
  bit            mdone [2];
  exp_t          q0 [$];
  exp_t          q1 [$];
  int            en_cnt;
  int            checks;
  int            errors;

  onchip_mem_avl_slave #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .READ_LATENCY(1), .CLEAR_ON_RESET(0)
  ) u_lat1 (
    .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .clken(clken), .reset_req(reset_req), .clear_req(clear_req),
    .readdata(rdata[0]), .readdatavalid(rdv[0]), .waitrequest(wreq[0]),
    .clear_busy(busy[0]), .clear_done(done[0])
`ifdef ONCHIP_MEM_OOR_ERR_EN
    , .oor_clr(oor_clr), .oor_err(oor_err[0]), .oor_addr(oor_addr[0])
`endif
  );

  onchip_mem_avl_slave #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .READ_LATENCY(2), .CLEAR_ON_RESET(1)
  ) u_lat2 (
    .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .clken(clken), .reset_req(reset_req), .clear_req(clear_req),
    .readdata(rdata[1]), .readdatavalid(rdv[1]), .waitrequest(wreq[1]),
    .clear_busy(busy[1]), .clear_done(done[1])
`ifdef ONCHIP_MEM_OOR_ERR_EN
    , .oor_clr(oor_clr), .oor_err(oor_err[1]), .oor_addr(oor_addr[1])
`endif
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Count enabled cycles; read timing is measured in enabled cycles.
  always @(posedge clk) begin
    if (clken && !reset_req) en_cnt <= en_cnt + 1;
  end

  task automatic checkOutput(input string name, input int inst,
                             input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s inst%0d: got %0h expected %0h at %0t", name, inst, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic cs, input logic rd, input logic wr,
                               input logic [AW-1:0] a, input logic [BW-1:0] be,
                               input logic [DW-1:0] wd, input logic ce,
                               input logic rr, input logic cr);
    @(posedge clk);
    #1;
    chipselect = cs; read = rd; write = wr; address = a; byteenable = be;
    writedata = wd; clken = ce; reset_req = rr; clear_req = cr;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((mbusy[0] || mbusy[1]) && n < 200) begin
      idle();
      n++;
    end
    checkOutput("idle_wait", 0, 64'(busy), 64'(0));
  endtask

  // Reference model: expected control outputs, memory contents and read responses.
  always @(negedge clk) begin : model
    logic          en_now;
    logic          wreq_exp;
    logic          hit;
    int            a;
    logic [DW-1:0] mask;
    exp_t          e;
    en_now = clken & ~reset_req;
    a = int'(address);
    if (!reset_n) begin
      q0.delete();
      q1.delete();
      for (int i = 0; i < 2; i++) begin
        checkOutput("reset_valid", i, 64'(rdv[i]), 64'(0));
        checkOutput("reset_data", i, 64'(rdata[i]), 64'(0));
        checkOutput("reset_done", i, 64'(done[i]), 64'(0));
        checkOutput("reset_busy", i, 64'(busy[i]), 64'(COR[i]));
        mbusy[i] = COR[i];
        mleft[i] = DEPTH;
        mdone[i] = 1'b0;
        if (COR[i]) for (int w = 0; w < DEPTH; w++) mmem[i][w] = '0;
`ifdef ONCHIP_MEM_OOR_ERR_EN
        checkOutput("reset_oor_err", i, 64'(oor_err[i]), 64'(0));
        moor_err[i] = 1'b0;
        moor_addr[i] = '0;
`endif
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        wreq_exp = ~en_now | mbusy[i];
        checkOutput("waitrequest", i, 64'(wreq[i]), 64'(wreq_exp));
        checkOutput("clear_busy", i, 64'(busy[i]), 64'(mbusy[i]));
        checkOutput("clear_done", i, 64'(done[i]), 64'(mdone[i]));
        hit = chipselect & (read | write) & ~wreq_exp;
`ifdef ONCHIP_MEM_OOR_ERR_EN
        checkOutput("oor_err", i, 64'(oor_err[i]), 64'(moor_err[i]));
        checkOutput("oor_addr", i, 64'(oor_addr[i]), 64'(moor_addr[i]));
        if (oor_clr) begin
          moor_err[i] = 1'b0;
          moor_addr[i] = '0;
        end
        if (hit && a >= DEPTH && !moor_err[i]) begin
          moor_err[i] = 1'b1;
          moor_addr[i] = address;
        end
`endif
        if (hit && write) begin
          if (a < DEPTH) begin
            mask = '0;
            for (int b = 0; b < BW; b++) mask[b*8 +: 8] = {8{byteenable[b]}};
            mmem[i][a] = (mmem[i][a] & ~mask) | (writedata & mask);
          end
        end else if (hit && read) begin
          e.data = (a < DEPTH) ? mmem[i][a] : '0;
          e.due  = en_cnt + i + 1;
          if (i == 0) q0.push_back(e);
          else q1.push_back(e);
        end
        mdone[i] = 1'b0;
        if (mbusy[i]) begin
          if (en_now) begin
            mleft[i]--;
            if (mleft[i] == 0) begin
              mbusy[i] = 1'b0;
              mdone[i] = 1'b1;
            end
          end
        end else if (clear_req && en_now) begin
          mbusy[i] = 1'b1;
          mleft[i] = DEPTH;
          for (int w = 0; w < DEPTH; w++) mmem[i][w] = '0;
        end
      end
    end
  end

  // Monitor: compare every presented read response against the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    bit   have;
    logic en_now;
    en_now = clken & ~reset_req;
    if (reset_n) begin
      for (int i = 0; i < 2; i++) begin
        have = 1'b0;
        e = '0;
        if (i == 0 && q0.size() > 0) begin have = 1'b1; e = q0[0]; end
        if (i == 1 && q1.size() > 0) begin have = 1'b1; e = q1[0]; end
        if (!en_now) begin
          checkOutput("stall_valid", i, 64'(rdv[i]), 64'(0));
        end else if (rdv[i]) begin
          if (!have) begin
            checkOutput("spurious_valid", i, 64'(rdv[i]), 64'(0));
          end else begin
            if (i == 0) void'(q0.pop_front());
            else void'(q1.pop_front());
            checkOutput("read_data", i, 64'(rdata[i]), 64'(e.data));
            checkOutput("read_timing", i, 64'(en_cnt), 64'(e.due));
          end
        end else if (have && e.due <= en_cnt) begin
          checkOutput("missing_valid", i, 64'(rdv[i]), 64'(1));
          if (i == 0) void'(q0.pop_front());
          else void'(q1.pop_front());
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  // Stimulus: directed scenarios, then randomized traffic, then reset mid-clear.
  initial begin
    clk = 1'b0; reset_n = 1'b0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
    address = '0; byteenable = '0; writedata = '0; clken = 1'b1;
    reset_req = 1'b0; clear_req = 1'b0; en_cnt = 0; checks = 0; errors = 0;
`ifdef ONCHIP_MEM_OOR_ERR_EN
    oor_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    waitIdle();

    $display("[TB] clear both arrays, second request mid-clear");
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b1);
    repeat (5) idle();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b1);
    waitIdle();
    idle();

    $display("[TB] byte-lane writes");
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd5, 4'hF, 32'hAABBCCDD, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd5, 4'h5, 32'h11223344, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd5, 4'h0, '0, 1'b1, 1'b0, 1'b0);
    repeat (3) idle();

    $display("[TB] back-to-back reads");
    for (int a = 0; a < 3; a++)
      applyStimulus(1'b1, 1'b0, 1'b1, AW'(a), 4'hF, DW'(32'h10 + a), 1'b1, 1'b0, 1'b0);
    for (int a = 0; a < 3; a++)
      applyStimulus(1'b1, 1'b1, 1'b0, AW'(a), 4'h0, '0, 1'b1, 1'b0, 1'b0);
    repeat (3) idle();

    $display("[TB] stall after read");
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd1, 4'h0, '0, 1'b1, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    repeat (4) idle();

    $display("[TB] out-of-range access");
    applyStimulus(1'b1, 1'b0, 1'b1, AW'(DEPTH), 4'hF, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, AW'(DEPTH), 4'h0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, AW'(DEPTH - 1), 4'h0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, AW'(DEPTH + 3), 4'h0, '0, 1'b1, 1'b0, 1'b0);
    repeat (3) idle();
`ifdef ONCHIP_MEM_OOR_ERR_EN
    oor_clr = 1'b1;
    idle();
    oor_clr = 1'b0;
    repeat (2) idle();
`endif

    $display("[TB] randomized traffic");
    for (int n = 0; n < 600; n++) begin
      logic [AW-1:0] ra;
      int op;
      op = int'($urandom_range(0, 2));
      ra = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(DEPTH, 31))
                                        : AW'($urandom_range(0, DEPTH - 1));
`ifdef ONCHIP_MEM_OOR_ERR_EN
      oor_clr = ($urandom_range(0, 30) == 0);
`endif
      applyStimulus($urandom_range(0, 9) < 8, op != 1, op != 0, ra,
                    BW'($urandom), DW'($urandom), $urandom_range(0, 7) != 0,
                    $urandom_range(0, 15) == 0, $urandom_range(0, 99) == 0);
    end
`ifdef ONCHIP_MEM_OOR_ERR_EN
    oor_clr = 1'b0;
`endif
    idle();
    waitIdle();
    repeat (3) idle();

    $display("[TB] reset during clear");
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b1);
    repeat (7) idle();
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd3, 4'h0, '0, 1'b1, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    idle();
    reset_n = 1'b1;
    waitIdle();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b1);
    idle();
    waitIdle();
    for (int a = 0; a <= DEPTH; a++)
      applyStimulus(1'b1, 1'b1, 1'b0, AW'(a), 4'h0, '0, 1'b1, 1'b0, 1'b0);
    repeat (5) idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
